// File: rtl/driver_74hc595.sv
// Continuous refresh driver for four daisy-chained 74HC595 chains sharing SRCLK/RCLK.
// Optional output-enable control is built when DRIVER_74HC595_OE_EN is defined.
module driver_74hc595 #(
    parameter int WIDTH = 16,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [WIDTH-1:0] data_3,
    output logic             SER_0,
    output logic             SER_1,
    output logic             SER_2,
    output logic             SER_3,
    output logic             SRCLK,
    output logic             RCLK,
    output logic             frame_done
`ifdef DRIVER_74HC595_OE_EN
    ,
    input  logic             blank,
    output logic             OEn
`endif
);

    // state    | meaning
    // LOAD     | outputs idle, snapshot data words at end of tick
    // SHIFT_LO | present next bit on SER, SRCLK low
    // SHIFT_HI | SRCLK high, SER held; shift shadow on exit
    // LATCH    | RCLK high, frame_done on first clk
    typedef enum logic [1:0] {LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    localparam int BW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [7:0]       div_cnt;
    logic             tick_end;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0] data_w  [4];
    logic [WIDTH-1:0] sh      [4];
    logic [WIDTH-1:0] sh_nxt  [4];
    logic [3:0]       ser_q, ser_nxt;
    logic             srclk_nxt, rclk_nxt;

    assign data_w[0] = data_0;
    assign data_w[1] = data_1;
    assign data_w[2] = data_2;
    assign data_w[3] = data_3;

    assign tick_end = (div_cnt == 8'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            div_cnt <= tick_end ? 8'd0 : div_cnt + 8'd1;
            if (tick_end) begin
                state   <= state_nxt;
                bit_cnt <= bit_cnt_nxt;
            end
        end
    end

    // Next-state plus the exit actions of the current state; applied at tick end only.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        for (int k = 0; k < 4; k++) sh_nxt[k] = sh[k];
        case (state)
            LOAD: begin
                for (int k = 0; k < 4; k++) sh_nxt[k] = data_w[k];
                bit_cnt_nxt = '0;
                state_nxt   = SHIFT_LO;
            end
            SHIFT_LO: state_nxt = SHIFT_HI;
            SHIFT_HI: begin
                for (int k = 0; k < 4; k++) sh_nxt[k] = {sh[k][WIDTH-2:0], 1'b0};
                bit_cnt_nxt = bit_cnt + 1'b1;
                state_nxt   = (bit_cnt == BW'(WIDTH - 1)) ? LATCH : SHIFT_LO;
            end
            LATCH:   state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Outputs are registered alongside the state so they track it without skew.
    always_comb begin
        srclk_nxt = (state_nxt == SHIFT_HI);
        rclk_nxt  = (state_nxt == LATCH);
        for (int k = 0; k < 4; k++)
            ser_nxt[k] = (state_nxt == SHIFT_LO) ? sh_nxt[k][WIDTH-1] : ser_q[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) sh[k] <= '0;
            ser_q      <= '0;
            SRCLK      <= 1'b0;
            RCLK       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick_end && (state_nxt == LATCH);
            if (tick_end) begin
                for (int k = 0; k < 4; k++) sh[k] <= sh_nxt[k];
                ser_q <= ser_nxt;
                SRCLK <= srclk_nxt;
                RCLK  <= rclk_nxt;
            end
        end
    end

    assign SER_0 = ser_q[0];
    assign SER_1 = ser_q[1];
    assign SER_2 = ser_q[2];
    assign SER_3 = ser_q[3];

`ifdef DRIVER_74HC595_OE_EN
    // Keep the 595 outputs disabled until the first complete frame has been latched.
    logic oe_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            oe_armed <= 1'b0;
            OEn      <= 1'b1;
        end else if (frame_done || oe_armed) begin
            oe_armed <= 1'b1;
            OEn      <= blank;
        end
    end
`endif

endmodule

// File: tb/tb_driver_74hc595.sv
// Bench for driver_74hc595: per-clk frame-timing reference plus a behavioural 595 model per chain,
// run against a DIV=1 and a DIV=3 instance.
module tb_driver_74hc595;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] d [4];
    logic        blank = 1'b0;

    logic [3:0]  ser_a, ser_b;
    logic        srclk_a, srclk_b, rclk_a, rclk_b, fd_a, fd_b;
`ifdef DRIVER_74HC595_OE_EN
    logic        oen_a, oen_b;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    driver_74hc595 #(.WIDTH(16), .DIV(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .data_0(d[0]), .data_1(d[1]), .data_2(d[2]), .data_3(d[3]),
        .SER_0(ser_a[0]), .SER_1(ser_a[1]), .SER_2(ser_a[2]), .SER_3(ser_a[3]),
        .SRCLK(srclk_a), .RCLK(rclk_a), .frame_done(fd_a)
`ifdef DRIVER_74HC595_OE_EN
        , .blank(blank), .OEn(oen_a)
`endif
    );

    driver_74hc595 #(.WIDTH(16), .DIV(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .data_0(d[0]), .data_1(d[1]), .data_2(d[2]), .data_3(d[3]),
        .SER_0(ser_b[0]), .SER_1(ser_b[1]), .SER_2(ser_b[2]), .SER_3(ser_b[3]),
        .SRCLK(srclk_b), .RCLK(rclk_b), .frame_done(fd_b)
`ifdef DRIVER_74HC595_OE_EN
        , .blank(blank), .OEn(oen_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: clk count since reset release, and the reset level the DUT last sampled.
    int   cyc = 0;
    logic rst_q = 1'b1;

    always @(posedge clk) begin
        rst_q <= reset;
        cyc   <= reset ? 0 : cyc + 1;
    end

    logic [15:0] fr       [2][4];
    logic [15:0] last_lat [2][4];
    logic [15:0] sr       [2][4];
    logic [15:0] lat      [2][4];
    logic [3:0]  ser_prev [2];
    logic        srclk_prev [2];
    logic        rclk_prev  [2];
    logic        armed      [2];
    logic        blank_prev = 1'b0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                fr[i][k] = '0; last_lat[i][k] = '0; sr[i][k] = '0; lat[i][k] = '0;
            end
            ser_prev[i] = '0; srclk_prev[i] = 1'b0; rclk_prev[i] = 1'b0; armed[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int dv, p, t, s, bi;
            logic e_sr, e_rc, e_fd, shifting;
            logic [3:0] ser;
            logic srclk, rclk, fd;
`ifdef DRIVER_74HC595_OE_EN
            logic oen;
            oen = (i == 0) ? oen_a : oen_b;
`endif
            dv    = (i == 0) ? 1 : 3;
            ser   = (i == 0) ? ser_a : ser_b;
            srclk = (i == 0) ? srclk_a : srclk_b;
            rclk  = (i == 0) ? rclk_a : rclk_b;
            fd    = (i == 0) ? fd_a : fd_b;

            // Frame = 34 ticks: tick 0 load, ticks 1..32 alternate low/high per bit, tick 33 latch.
            p = cyc % (dv * 34);
            t = p / dv;
            s = p % dv;
            e_sr     = (t >= 2) && (t <= 32) && (t % 2 == 0);
            e_rc     = (t == 33);
            e_fd     = e_rc && (s == 0);
            shifting = (t >= 1) && (t <= 32);
            bi       = 15 - (t - 1) / 2;

            if (rst_q) begin
                check($sformatf("rst_ser[%0d]", i), 32'(ser), 32'(0));
                check($sformatf("rst_srclk[%0d]", i), 32'(srclk), 32'(0));
                check($sformatf("rst_rclk[%0d]", i), 32'(rclk), 32'(0));
                check($sformatf("rst_fd[%0d]", i), 32'(fd), 32'(0));
`ifdef DRIVER_74HC595_OE_EN
                check($sformatf("rst_oen[%0d]", i), 32'(oen), 32'(1));
`endif
                for (int k = 0; k < 4; k++)
                    check($sformatf("hold_latch[%0d][%0d]", i, k), 32'(lat[i][k]), 32'(last_lat[i][k]));
                armed[i] = 1'b0;
            end else begin
                check($sformatf("srclk[%0d]", i), 32'(srclk), 32'(e_sr));
                check($sformatf("rclk[%0d]", i), 32'(rclk), 32'(e_rc));
                check($sformatf("frame_done[%0d]", i), 32'(fd), 32'(e_fd));
                if (shifting)
                    for (int k = 0; k < 4; k++)
                        check($sformatf("ser[%0d][%0d]", i, k), 32'(ser[k]), 32'(fr[i][k][bi]));
`ifdef DRIVER_74HC595_OE_EN
                check($sformatf("oen[%0d]", i), 32'(oen), 32'(armed[i] ? blank_prev : 1'b1));
                if (e_fd) armed[i] = 1'b1;
`endif
            end
            if (p == dv - 1)
                for (int k = 0; k < 4; k++) fr[i][k] = d[k];

            // Behavioural 595: shift on SRCLK rise with the SER level present before the edge.
            if (srclk && !srclk_prev[i])
                for (int k = 0; k < 4; k++) sr[i][k] = {sr[i][k][14:0], ser_prev[i][k]};
            if (rclk && !rclk_prev[i])
                for (int k = 0; k < 4; k++) begin
                    lat[i][k] = sr[i][k];
                    check($sformatf("latch[%0d][%0d]", i, k), 32'(lat[i][k]), 32'(fr[i][k]));
                    last_lat[i][k] = fr[i][k];
                end
            ser_prev[i]   = ser;
            srclk_prev[i] = srclk;
            rclk_prev[i]  = rclk;
        end
        blank_prev = blank;
    end

    initial begin
        d[0] = 16'h0000; d[1] = 16'hFFFF; d[2] = 16'h8001; d[3] = 16'h1234;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 1; c <= 354; c++) begin
            @(posedge clk);
            #1;
            if (c == 20) d[0] = 16'h00FF;
            if (c == 44) d[0] = 16'hFF00;
            if (c == 80) d[0] = 16'hA5C3;
            if (c > 100 && (c % 34) == 17)
                for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
            if (c >= 150 && c < 300) blank = 1'($urandom);
            if (c == 310) blank = 1'b1;
            if (c == 320) blank = 1'b0;
            // c == 354 is tick 14 of frame 10: SRCLK has just risen for the 7th time.
            if (c == 354) reset = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 1; c <= 140; c++) begin
            @(posedge clk);
            #1;
            if (c == 50)
                for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
            if (c == 60) blank = 1'b1;
            if (c == 62) blank = 1'b0;
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
